count_sched: RTL and testbench
==============================

Name: count_sched

Overview:
- Run-control scheduler for the counter20 datapath.
- Replaces a free-running divided clock with a single-clock-domain, one-cycle `tick` enable generated from the system clock.
- Sequences a modulo-(CNT_MAX+1) display counter through the states IDLE, RUN and PAUSE under start, stop, clear and step commands.
- Sits between the synchronised/debounced button logic and the 7-segment display driver.

Parameters:
- DIV, 50000000, system clocks per tick in RUN (≥2).
- CNT_MAX, 19, terminal count value; count wraps to 0 after it.
- DW, $clog2(DIV), divider register width (derived, not overridden).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- start  input  1  single-cycle command pulse, already synchronous to clock.
- stop  input  1  single-cycle command pulse.
- clear  input  1  single-cycle command pulse.
- step  input  1  single-cycle manual-advance pulse.
- tick  output  1  one-cycle enable marking a counter advance.
- count  output  5  current count, 0..CNT_MAX.
- wrap  output  1  one-cycle pulse when count rolls CNT_MAX→0.
- running  output  1  1 while state==RUN.
- state_o  output  2  encoded FSM state for debug/LEDs.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, div_cnt=0, count=0.
  - tick=0, wrap=0, running=0, state_o=IDLE.
- All outputs are registered; no combinational paths from inputs to outputs.
- Command priority when pulses coincide: clear > stop > start > step.
- FSM states: IDLE, RUN, PAUSE.
- IDLE:
  - start → RUN, with div_cnt=0.
  - step → stay IDLE; tick=1 next cycle and count advances.
  - stop → no effect.
- RUN:
  - div_cnt increments every clock.
  - When div_cnt==DIV-1: div_cnt←0, tick←1, count advances, all on the same edge. First tick is therefore DIV clocks after the start edge.
  - stop → PAUSE; div_cnt is held, not cleared.
  - step and start → ignored.
- PAUSE:
  - start → RUN; div_cnt resumes from its held value, so the remaining interval is preserved.
  - step → tick=1 next cycle and count advances; div_cnt unchanged.
  - stop → IDLE, with div_cnt←0; count is kept.
- clear, from any state, on the next edge:
  - state=IDLE, div_cnt=0, count=0.
  - tick=0, wrap=0.
  - Overrides a coincident divider terminal cycle: no tick is emitted.
- Count advance:
  - If count==CNT_MAX, count←0 and wrap←1 in the same cycle as tick.
  - Otherwise count←count+1 and wrap←0.
  - count never exceeds CNT_MAX.
- tick and wrap are high for exactly one clock per event and never in back-to-back cycles from the divider. Step pulses on consecutive cycles may produce consecutive ticks.
- A stop on the divider terminal cycle:
  - The tick for that cycle is still produced, because the terminal compare is decided on that edge.
  - The state moves to PAUSE with div_cnt=0.
- running and state_o update on the same edge as the state change.
- Reset mid-RUN: outputs go to reset values immediately. After reset deasserts, the block sits in IDLE until start.
- Arithmetic:
  - div_cnt is an unsigned DW-bit value.
  - Comparison is against DIV-1 as a DW-bit constant.
  - count is an unsigned 5-bit value; the block is invalid for CNT_MAX > 31 (elaboration-time check).

Decomposition:
- Package count_sched_pkg holds:
  - typedef sched_state_t (2-bit enum IDLE=0, RUN=1, PAUSE=2);
  - the default DIV and CNT_MAX constants.
- One natural sub-module: tick_div, the DW-bit divider with enable, hold and clear inputs and a terminal-count pulse output.
- The FSM, count register and wrap logic stay in the top module.

Test Plan (DIV=4, CNT_MAX=19 unless noted):
- Reset released, start pulse at cycle 0 → tick high at cycles 4, 8 and 12; count 1, 2, 3; running=1 from cycle 1.
- Run until count==19, then wait 4 more clocks → count=0 with tick=1 and wrap=1 in the same cycle; wrap low the next cycle.
- Start; stop at cycle 2 (div_cnt=2); wait 10 clocks → no ticks. Start again → next tick exactly 2 clocks later (interval preserved).
- In IDLE, three step pulses on consecutive cycles → three consecutive ticks, count=3. Step while in RUN → no extra tick.
- Start, stop and clear asserted in the same cycle while in RUN at count=7 → next cycle state=IDLE, count=0, tick=0, running=0.
- reset asserted low mid-cycle while in RUN at count=12 → count=0, tick=0 and state_o=IDLE immediately, without waiting for a clock edge. After release, no ticks occur until start.

Source files
------------

// File: rtl/count_sched_pkg.sv
// Shared types and default sizing for the count_sched run-control scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sched_state_t;

    // 50 MHz system clock -> one count advance per second by default.
    localparam int DEF_DIV     = 50000000;
    localparam int DEF_CNT_MAX = 19;

endpackage

// File: rtl/count_sched_tick_div.sv
// Tick divider: DW-bit counter that reports its terminal cycle while enabled.
// Latency: tc is combinational from the held count; count updates on the next edge.
// Backpressure: none; hold freezes progress except that a terminal count still wraps.
//
// Ports: clock/reset (async active-low), en (running), hold (freeze this edge),
//        clr (synchronous zero, wins over everything), tc (terminal cycle while en).
module count_sched_tick_div #(
    parameter int DIV = 4,
    parameter int DW  = $clog2(DIV)
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic hold,
    input  logic clr,
    output logic tc
);

    localparam logic [DW-1:0] TERM = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          at_term;

    assign at_term = (div_cnt == TERM);
    assign tc      = en & at_term;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            // The terminal compare is decided on this edge, so a hold arriving
            // on the terminal cycle still wraps the interval back to zero.
            if (at_term) begin
                div_cnt <= '0;
            end else if (!hold) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sched.sv
// Run-control scheduler: IDLE/RUN/PAUSE FSM producing a one-cycle tick and a mod-(CNT_MAX+1) count.
// Latency: all outputs registered; commands take effect on the edge that samples them.
// Backpressure: none; single-cycle command pulses, priority clear > stop > start > step.
//
// Ports: clock, reset (async active-low), start/stop/clear/step (sync pulses),
//        tick (advance strobe), count (0..CNT_MAX), wrap (rollover strobe),
//        running (state==RUN), state_o (encoded state).
module count_sched
    import count_sched_pkg::*;
#(
    parameter int DIV     = DEF_DIV,
    parameter int CNT_MAX = DEF_CNT_MAX
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       step,
    output logic       tick,
    output logic [4:0] count,
    output logic       wrap,
    output logic       running,
    output logic [1:0] state_o
);

    localparam int          DW      = $clog2(DIV);
    localparam logic [4:0]  CNT_TOP = 5'(CNT_MAX);

    generate
        if (CNT_MAX > 31 || CNT_MAX < 0) begin : g_bad_cnt_max
            $error("count_sched: CNT_MAX must be within 0..31");
        end
        if (DIV < 2) begin : g_bad_div
            $error("count_sched: DIV must be at least 2");
        end
    endgenerate

    sched_state_t state, state_nxt;
    logic [4:0]   count_nxt;
    logic         wrap_nxt;
    logic         adv;
    logic         div_en;
    logic         div_clr;
    logic         div_tc;

    // The divider only runs in RUN; a clear on the terminal cycle must suppress the tick.
    assign div_en = (state == RUN) && !clear;

    count_sched_tick_div #(
        .DIV (DIV),
        .DW  (DW)
    ) u_tick_div (
        .clock (clock),
        .reset (reset),
        .en    (div_en),
        .hold  (stop),
        .clr   (div_clr),
        .tc    (div_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tick  <= adv;
            wrap  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        div_clr   = 1'b0;

        if (clear) begin
            state_nxt = IDLE;
            div_clr   = 1'b1;
        end else begin
            // Only the highest-priority pulse present is acted on.
            unique case (state)
                IDLE: begin
                    if (stop) begin
                        state_nxt = IDLE;
                    end else if (start) begin
                        state_nxt = RUN;
                        div_clr   = 1'b1;
                    end else if (step) begin
                        adv = 1'b1;
                    end
                end
                RUN: begin
                    adv = div_tc;
                    if (stop) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_nxt = IDLE;
                        div_clr   = 1'b1;
                    end else if (start) begin
                        state_nxt = RUN;
                    end else if (step) begin
                        adv = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    div_clr   = 1'b1;
                end
            endcase
        end

        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (adv) begin
            if (count >= CNT_TOP) begin
                count_nxt = '0;
                wrap_nxt  = 1'b1;
            end else begin
                count_nxt = count + 5'd1;
            end
        end
    end

    assign running = (state == RUN);
    assign state_o = state;

endmodule

// File: tb/tb_count_sched.sv
module tb_count_sched;

    localparam int DIV_T = 4;
    localparam int CMAX  = 19;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       clear = 1'b0;
    logic       step  = 1'b0;
    logic       tick;
    logic [4:0] count;
    logic       wrap;
    logic       running;
    logic [1:0] state_o;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: mode 0=idle 1=run 2=pause, elapsed clocks in the interval, count value.
    int m_mode = 0;
    int m_el   = 0;
    int m_cnt  = 0;
    int m_tick = 0;
    int m_wrap = 0;

    count_sched #(.DIV(DIV_T), .CNT_MAX(CMAX)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .step    (step),
        .tick    (tick),
        .count   (count),
        .wrap    (wrap),
        .running (running),
        .state_o (state_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_el = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
    endtask

    task automatic model_edge(input bit a_start, input bit a_stop, input bit a_clear, input bit a_step);
        bit advance;
        advance = 0;
        if (a_clear) begin
            m_mode = 0; m_el = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (!a_stop && a_start) begin
                m_mode = 1; m_el = 0;
            end else if (!a_stop && a_step) begin
                advance = 1;
            end
        end else if (m_mode == 1) begin
            // An interval completes after DIV clocks in RUN, regardless of a stop.
            if (m_el + 1 == DIV_T) begin
                m_el = 0;
                advance = 1;
            end else if (!a_stop) begin
                m_el = m_el + 1;
            end
            if (a_stop) m_mode = 2;
        end else begin
            if (a_stop) begin
                m_mode = 0; m_el = 0;
            end else if (a_start) begin
                m_mode = 1;
            end else if (a_step) begin
                advance = 1;
            end
        end
        m_tick = advance;
        m_wrap = advance && (m_cnt == CMAX);
        if (advance) m_cnt = (m_cnt + 1) % (CMAX + 1);
    endtask

    task automatic check_all();
        chk("tick", int'(tick), m_tick);
        chk("wrap", int'(wrap), m_wrap);
        chk("count", int'(count), m_cnt);
        chk("state", int'(state_o), m_mode);
        chk("running", int'(running), (m_mode == 1) ? 1 : 0);
    endtask

    // Drive one cycle of command pulses; outputs are checked 1 ns after the edge.
    task automatic cyc(input bit a_start, input bit a_stop, input bit a_clear, input bit a_step);
        start = a_start; stop = a_stop; clear = a_clear; step = a_step;
        @(posedge clock);
        model_edge(a_start, a_stop, a_clear, a_step);
        #1;
        check_all();
        start = 0; stop = 0; clear = 0; step = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic run_until(input int target);
        int k;
        k = 0;
        while (int'(count) != target && k < 300) begin
            cyc(0, 0, 0, 0);
            k++;
        end
        chk("reach_count", int'(count), target);
    endtask

    initial begin
        int nt;
        model_reset();
        #12;
        check_all();
        #8 reset = 1'b1;

        // Free-running: ticks every DIV clocks after the start edge.
        cyc(1, 0, 0, 0);
        chk("running_after_start", int'(running), 1);
        nt = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 0, 0);
            if (tick) nt++;
            if (i == 4 || i == 8 || i == 12) chk("tick_at_interval", int'(tick), 1);
        end
        chk("ticks_in_12", nt, 3);
        chk("count_after_12", int'(count), 3);

        // Rollover.
        run_until(CMAX);
        idle(3);
        chk("pre_wrap_tick", int'(tick), 0);
        cyc(0, 0, 0, 0);
        chk("wrap_count", int'(count), 0);
        chk("wrap_tick", int'(tick), 1);
        chk("wrap_pulse", int'(wrap), 1);
        cyc(0, 0, 0, 0);
        chk("wrap_low", int'(wrap), 0);

        // Pause preserves the remaining interval.
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            if (tick) nt++;
        end
        chk("paused_ticks", nt, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("resume_tick_early", int'(tick), 0);
        cyc(0, 0, 0, 0);
        chk("resume_tick", int'(tick), 1);

        // Manual steps in IDLE, then a step in RUN.
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            chk("step_tick", int'(tick), 1);
        end
        chk("step_count", int'(count), 3);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("step_in_run", int'(tick), 0);

        // Clear beats stop and start.
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        run_until(7);
        cyc(1, 1, 1, 0);
        chk("clr_state", int'(state_o), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_tick", int'(tick), 0);
        chk("clr_running", int'(running), 0);

        // Stop landing on the terminal cycle still ticks.
        cyc(1, 0, 0, 0);
        idle(3);
        cyc(0, 1, 0, 0);
        chk("stop_term_tick", int'(tick), 1);
        cyc(1, 0, 0, 0);
        idle(3);
        chk("stop_term_restart", int'(tick), 0);
        cyc(0, 0, 0, 0);
        chk("stop_term_full", int'(tick), 1);

        // Asynchronous reset mid-run.
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        run_until(12);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_count", int'(count), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_state", int'(state_o), 0);
        chk("arst_running", int'(running), 0);
        #3 reset = 1'b1;
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            if (tick) nt++;
        end
        chk("post_reset_ticks", nt, 0);

        // Random command mix against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 10) == 0,
                ($urandom % 40) == 0, ($urandom % 6) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
